// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: owns the single RAM port. After reset it copies INIT_WORDS
// words from the init ROM into RAM, then serves CPU accesses. The word at
// IO_ADDR is not RAM: reads return the switches and writes load the hex display.
module mem_io_arbiter #(
  parameter int          INIT_WORDS = 256,
  parameter int          MEM_LAT    = 2,
  parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] init_addr,
  input  logic [15:0] init_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [9:0]  SW,
  output logic [15:0] hex_data,
  output logic        busy_init
);

  typedef enum logic [2:0] {INIT, IDLE, WR, RD, DONE} state_t;

  localparam logic [15:0] LAST_WORD = 16'(INIT_WORDS - 1);

  state_t state, state_nxt;

  logic [15:0]        cnt;
  logic [15:0]        req_addr;
  logic [15:0]        req_wdata;
  logic               req_we;
  // One-hot marker walking through the RAM read latency; the top bit marks
  // the cycle in which mem_rdata is valid for the latched address.
  logic [MEM_LAT-1:0] vld_pipe;

  logic accept, is_io, rd_last;

  assign accept  = (state == IDLE) && cpu_req;
  assign is_io   = (cpu_addr == IO_ADDR);
  assign rd_last = vld_pipe[MEM_LAT-1];

  // State register; reset aborts any access in flight and restarts the copy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= INIT;
    else        state <= state_nxt;
  end

  // Next-state decode and RAM port / status outputs.
  always_comb begin
    state_nxt = state;
    busy_init = (state == INIT);
    cpu_ready = (state == DONE);
    init_addr = cnt;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_we    = 1'b0;
    case (state)
      INIT: begin
        // Gated by Reset so the RAM is never written while reset is held.
        mem_we    = Reset;
        mem_addr  = cnt;
        mem_wdata = init_data;
        if (cnt == LAST_WORD) state_nxt = IDLE;
      end
      IDLE: begin
        if (cpu_req) begin
          if (is_io)       state_nxt = DONE;
          else if (cpu_we) state_nxt = WR;
          else             state_nxt = RD;
        end
      end
      WR: begin
        mem_we    = req_we;
        state_nxt = DONE;
      end
      RD: begin
        if (rd_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Copy counter, request latch, read-latency tracking and I/O registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      vld_pipe  <= '0;
      cpu_rdata <= '0;
      hex_data  <= '0;
    end else begin
      if (state == INIT) cnt <= cnt + 16'd1;

      if (accept && !is_io && !cpu_we) vld_pipe <= MEM_LAT'(1);
      else                             vld_pipe <= vld_pipe << 1;

      if (accept) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_we    <= cpu_we;
        if (is_io) begin
          if (cpu_we) hex_data  <= cpu_wdata;
          else        cpu_rdata <= {6'b0, SW};
        end
      end

      if (state == RD && rd_last) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: small ROM and synchronous-read RAM models, a
// scoreboard of expected read data popped on every cpu_ready pulse, and one
// task per scenario.
module tb_mem_io_arbiter;

  localparam int          INIT_WORDS = 4;
  localparam int          MEM_LAT    = 2;
  localparam logic [15:0] IO_ADDR    = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [15:0] init_addr, init_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [9:0]  SW;
  logic [15:0] hex_data;
  logic        busy_init;

  mem_io_arbiter #(.INIT_WORDS(INIT_WORDS), .MEM_LAT(MEM_LAT), .IO_ADDR(IO_ADDR)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .init_addr(init_addr), .init_data(init_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .SW(SW), .hex_data(hex_data), .busy_init(busy_init)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Init ROM model, combinational read.
  logic [15:0] rom [0:3];
  initial begin
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
  end
  always_comb init_data = (init_addr < 16'd4) ? rom[init_addr[1:0]] : 16'h0000;

  // RAM model: one registered read stage, so data for an address held from
  // cycle T+1 is valid in T+2 (MEM_LAT = 2).
  logic [15:0] ram [0:255];
  logic [15:0] rdq = '0;
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge Clk) begin
    if (mem_we === 1'b1) ram[mem_addr[7:0]] <= mem_wdata;
    rdq <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = rdq;

  // Scoreboard: every completion carries the read data the CPU should see.
  typedef struct {logic rd; logic [15:0] data;} exp_t;
  exp_t        sb[$];
  logic [15:0] last_rd = '0;

  always @(negedge Clk) begin
    if (Reset === 1'b1 && cpu_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready rdata=%h", cpu_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cpu_rdata !== e.data) begin
          errors++;
          $display("FAIL sb_rdata rd=%0b got=%h exp=%h", e.rd, cpu_rdata, e.data);
        end
      end
    end
  end

  function automatic void push_exp(input logic we, input logic [15:0] rd_data);
    exp_t e;
    e.rd = !we;
    if (!we) last_rd = rd_data;
    e.data = last_rd;
    sb.push_back(e);
  endfunction

  // One access from an IDLE cycle; checks completion latency and RAM write count.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input int exp_lat, input int exp_we,
                           input string name);
    int n, we_cnt;
    bit seen;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    push_exp(we, exp_rd);
    we_cnt = (mem_we === 1'b1) ? 1 : 0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge Clk);
      n++;
      if (mem_we === 1'b1) we_cnt++;
      if (cpu_ready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d seen=%0b exp=%0d", name, n, seen, exp_lat);
    end
    checks++;
    if (we_cnt != exp_we) begin
      errors++;
      $display("FAIL %s_mem_we_cycles got=%0d exp=%0d", name, we_cnt, exp_we);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; SW = '0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({busy_init, cpu_ready, mem_we} !== 3'b100 || cpu_rdata !== 16'h0 || hex_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state busy/ready/we=%b rdata=%h hex=%h exp 100/0000/0000",
               {busy_init, cpu_ready, mem_we}, cpu_rdata, hex_data);
    end
  endtask

  // ROM copy after reset, with a RAM read already pending while the copy runs.
  task automatic test_init_copy();
    int n;
    bit seen;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
    push_exp(1'b0, 16'h3333);
    Reset = 1'b1;
    #1;
    for (int i = 0; i < INIT_WORDS; i++) begin
      if (i > 0) @(negedge Clk);
      checks++;
      if (mem_we !== 1'b1 || busy_init !== 1'b1 || mem_addr !== 16'(i) || mem_wdata !== rom[i]) begin
        errors++;
        $display("FAIL init_word%0d we=%b busy=%b addr=%h data=%h exp 1/1/%h/%h",
                 i, mem_we, busy_init, mem_addr, mem_wdata, 16'(i), rom[i]);
      end
    end
    @(negedge Clk);
    checks++;
    if (busy_init !== 1'b0 || mem_we !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_end busy=%b we=%b ready=%b exp 0/0/0", busy_init, mem_we, cpu_ready);
    end
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge Clk);
      n++;
      if (cpu_ready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != MEM_LAT + 1) begin
      errors++;
      $display("FAIL stalled_read_latency got=%0d seen=%0b exp=%0d", n, seen, MEM_LAT + 1);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_io();
    do_access(1'b1, IO_ADDR, 16'h0031, 16'h0, 1, 0, "io_write");
    checks++;
    if (hex_data !== 16'h0031) begin
      errors++;
      $display("FAIL io_write_hex got=%h exp=0031", hex_data);
    end
    SW = 10'h3FF;
    do_access(1'b0, IO_ADDR, 16'h0, 16'h03FF, 1, 0, "io_read_3ff");
    SW = 10'h155;
    do_access(1'b0, IO_ADDR, 16'h0, 16'h0155, 1, 0, "io_read_155");
    // One below the I/O word is plain RAM: full latency, data from RAM.
    do_access(1'b0, 16'hFFFE, 16'h0, 16'h0000, MEM_LAT + 1, 0, "ram_fffe");
    checks++;
    if (hex_data !== 16'h0031) begin
      errors++;
      $display("FAIL hex_hold got=%h exp=0031", hex_data);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    do_access(1'b1, 16'h0010, 16'hBEEF, 16'h0, 2, 1, "ram_write");
    do_access(1'b1, 16'h0000, 16'hAAAA, 16'h0, 2, 1, "ram_write0");
    do_access(1'b0, 16'h0000, 16'h0, 16'hAAAA, MEM_LAT + 1, 0, "ram_read0");
    // Read held high through DONE: one ready pulse, an IDLE gap, then re-accept.
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    push_exp(1'b0, 16'hBEEF);
    for (int k = 0; k < 2; k++) begin
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge Clk);
        n++;
        if (cpu_ready === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || n != MEM_LAT + 1) begin
        errors++;
        $display("FAIL held_read%0d_latency got=%0d seen=%0b exp=%0d", k, n, seen, MEM_LAT + 1);
      end
      if (k == 0) begin
        push_exp(1'b0, 16'hBEEF);
        @(negedge Clk);
        checks++;
        if (cpu_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_pulse_width got=%b exp=0", cpu_ready);
        end
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || hex_data !== 16'h0 || cpu_rdata !== 16'h0 || busy_init !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read ready=%b hex=%h rdata=%h busy=%b we=%b exp 0/0000/0000/1/0",
               cpu_ready, hex_data, cpu_rdata, busy_init, mem_we);
    end
    last_rd = '0;
    cpu_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0 || mem_wdata !== 16'h1111) begin
      errors++;
      $display("FAIL rerun_init we=%b addr=%h data=%h exp 1/0000/1111", mem_we, mem_addr, mem_wdata);
    end
    repeat (INIT_WORDS - 1) @(negedge Clk);
    do_access(1'b0, 16'h0000, 16'h0, 16'h1111, MEM_LAT + 1, 0, "read_after_rerun");
    do_access(1'b0, 16'h0003, 16'h0, 16'h4444, MEM_LAT + 1, 0, "read_rom3");
  endtask

  initial begin
    test_reset();
    test_init_copy();
    test_io();
    test_back_to_back();
    test_reset_mid_read();
    repeat (3) @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
